// File: rtl/jtdd_tilemap.sv
// ---------------------------------------------------------------------------
// jtdd_tilemap
//   CPU-writable 8x8 4bpp tile map layer with per-layer X/Y scroll, global
//   and per-tile horizontal flip, ROM-miss blanking and a transparency flag.
//   Two byte-wide map banks share one address port between the CPU and the
//   video scan: the low bank holds code LSBs, the high bank holds the code
//   MSBs, palette and per-tile flip.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   pxl_cen        pixel clock enable; the whole video pipeline steps on it
//   cen_E          CPU bus enable qualifying map RAM and scroll writes
//   cpu_AB         CPU address, bit 0 selects bank / scroll axis
//   cpu_wrn        CPU write strobe, active low
//   cpu_dout       CPU write data
//   char_cs        map RAM select (CPU takes the RAM port while high)
//   scr_cs         scroll register select (cpu_AB[0]: 0 = X, 1 = Y)
//   char_dout      map read data from the bank chosen by cpu_AB[0]
//   HPOS, VPOS     raster position
//   flip           global screen flip
//   rom_addr       graphics ROM byte address {code, column pair, row}
//   rom_cs         fetch request, high from the first fetch until reset
//   rom_data       ROM byte, two interleaved 4-bit pixels
//   rom_ok         rom_data is valid for the current rom_addr
//   char_pxl       {palette, colour} output pixel
//   char_opaque    high when the colour nibble is non-zero
// ---------------------------------------------------------------------------
module jtdd_tilemap #(
  parameter int CODEW    = 10,
  parameter int PALW     = 3,
  parameter int MAPW     = 10,
  parameter bit XFLIP_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pxl_cen,
  input  logic                cen_E,
  input  logic [MAPW:0]       cpu_AB,
  input  logic                cpu_wrn,
  input  logic [7:0]          cpu_dout,
  input  logic                char_cs,
  input  logic                scr_cs,
  output logic [7:0]          char_dout,
  input  logic [7:0]          HPOS,
  input  logic [7:0]          VPOS,
  input  logic                flip,
  output logic [CODEW+4:0]    rom_addr,
  output logic                rom_cs,
  input  logic [7:0]          rom_data,
  input  logic                rom_ok,
  output logic [PALW+3:0]     char_pxl,
  output logic                char_opaque
);

  localparam int MAP_DEPTH = 1 << MAPW;

  // -------------------------------------------------------------------------
  // Scroll registers (write-only from the CPU)
  // -------------------------------------------------------------------------
  logic [7:0] scrx_q, scry_q;

  // NOTE: sequential state is updated with <= so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrx_q <= '0;
      scry_q <= '0;
    end else if (cen_E && scr_cs && !cpu_wrn) begin
      if (cpu_AB[0]) scry_q <= cpu_dout;
      else           scrx_q <= cpu_dout;
    end
  end

  // -------------------------------------------------------------------------
  // Effective scan position, 8-bit wrap-around
  // -------------------------------------------------------------------------
  logic [7:0] hx, vy;
  logic [9:0] scan10;
  logic [MAPW-1:0] scan_addr, ram_addr;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise the block would hold state and infer a latch.
  always_comb begin
    hx        = (flip ? ~HPOS : HPOS) + scrx_q;
    vy        = (flip ? ~VPOS : VPOS) + scry_q;
    scan10    = {vy[7:3], hx[7:3]};
    scan_addr = MAPW'(scan10);
    // CPU owns the port while selected; the scan sees the CPU's entry then.
    ram_addr  = char_cs ? cpu_AB[MAPW:1] : scan_addr;
  end

  // -------------------------------------------------------------------------
  // Map RAM: two byte banks, asynchronous read, write gated by cen_E
  // -------------------------------------------------------------------------
  logic [7:0] lo_mem [0:MAP_DEPTH-1];
  logic [7:0] hi_mem [0:MAP_DEPTH-1];
  logic [7:0] lo_rd, hi_rd;

  // NOTE: the map arrays have no reset; software initialises them, and a
  // reset here would turn the RAM into a huge bank of flops.
  always_ff @(posedge clk) begin
    if (cen_E && char_cs && !cpu_wrn) begin
      if (cpu_AB[0]) hi_mem[cpu_AB[MAPW:1]] <= cpu_dout;
      else           lo_mem[cpu_AB[MAPW:1]] <= cpu_dout;
    end
  end

  assign lo_rd     = lo_mem[ram_addr];
  assign hi_rd     = hi_mem[ram_addr];
  assign char_dout = cpu_AB[0] ? hi_rd : lo_rd;

  // -------------------------------------------------------------------------
  // Tile entry decode
  // -------------------------------------------------------------------------
  logic [15:0]      hilo;
  logic [CODEW-1:0] code;
  logic [PALW-1:0]  pal;
  logic             tile_flip;
  logic [1:0]       col;
  logic             even;

  always_comb begin
    hilo      = {hi_rd, lo_rd};
    code      = hilo[CODEW-1:0];          // {hi[CODEW-9:0], lo}
    pal       = hi_rd[7 -: PALW];
    tile_flip = XFLIP_EN && hi_rd[3];
    // A flipped tile fetches its 2-pixel column pairs right to left.
    col       = hx[2:1] ^ {2{tile_flip}};
    even      = ~hx[0];
  end

  // Bits not used by the chosen parameter set are collected here.
  logic unused_bits;
  assign unused_bits = ^{hilo, scan10};

  // -------------------------------------------------------------------------
  // Pixel pipeline
  // -------------------------------------------------------------------------
  logic [CODEW+4:0] rom_addr_q;
  logic             rom_cs_q;
  logic [PALW-1:0]  pal_a_q, pal_b_q;
  logic             tf_a_q, tf_b_q;
  logic [7:0]       shift_q, shift_d;
  logic [PALW+3:0]  pxl_q;
  logic             opaque_q;
  logic             hflip;
  logic [3:0]       cur_nib;
  logic [7:0]       rom_sorted;

  always_comb begin
    hflip      = tf_b_q ^ flip;
    // Odd ROM bits form the upper nibble, even bits the lower one.
    rom_sorted = {rom_data[7], rom_data[5], rom_data[3], rom_data[1],
                  rom_data[6], rom_data[4], rom_data[2], rom_data[0]};
    cur_nib    = hflip ? shift_q[7:4] : shift_q[3:0];
    shift_d    = shift_q;
    if (even) begin
      // A ROM miss blanks the byte instead of stalling the scan.
      shift_d = rom_ok ? rom_sorted : 8'h00;
    end else begin
      shift_d = hflip ? {shift_q[3:0], 4'h0} : {4'h0, shift_q[7:4]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      pal_a_q    <= '0;
      pal_b_q    <= '0;
      tf_a_q     <= 1'b0;
      tf_b_q     <= 1'b0;
      shift_q    <= '0;
      pxl_q      <= '0;
      opaque_q   <= 1'b0;
    end else if (pxl_cen) begin
      shift_q  <= shift_d;
      pxl_q    <= {pal_b_q, cur_nib};
      opaque_q <= |cur_nib;
      if (even) begin
        // Stage A: issue the fetch for the current entry.
        rom_addr_q <= {code, col, vy[2:0]};
        rom_cs_q   <= 1'b1;
        pal_a_q    <= pal;
        tf_a_q     <= tile_flip;
        // Stage B: attributes follow the byte being loaded into shift_q.
        pal_b_q    <= pal_a_q;
        tf_b_q     <= tf_a_q;
      end
    end
  end

  assign rom_addr    = rom_addr_q;
  assign rom_cs      = rom_cs_q;
  assign char_pxl    = pxl_q;
  assign char_opaque = opaque_q;

endmodule

// File: tb/tb_jtdd_tilemap.sv
// ---------------------------------------------------------------------------
// tb_jtdd_tilemap
//   Directed bench for jtdd_tilemap with default parameters
//   (CODEW=10, PALW=3, MAPW=10, XFLIP_EN=1). Expected values are
//   hand-computed constants; the ROM is a single driven byte plus rom_ok.
// ---------------------------------------------------------------------------
module tb_jtdd_tilemap;

  logic        clk;
  logic        rst_n;
  logic        pxl_cen;
  logic        cen_E;
  logic [10:0] cpu_AB;
  logic        cpu_wrn;
  logic [7:0]  cpu_dout;
  logic        char_cs;
  logic        scr_cs;
  logic [7:0]  char_dout;
  logic [7:0]  HPOS;
  logic [7:0]  VPOS;
  logic        flip;
  logic [14:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic [6:0]  char_pxl;
  logic        char_opaque;

  int n_checks = 0;
  int n_errors = 0;

  jtdd_tilemap dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pxl_cen     (pxl_cen),
    .cen_E       (cen_E),
    .cpu_AB      (cpu_AB),
    .cpu_wrn     (cpu_wrn),
    .cpu_dout    (cpu_dout),
    .char_cs     (char_cs),
    .scr_cs      (scr_cs),
    .char_dout   (char_dout),
    .HPOS        (HPOS),
    .VPOS        (VPOS),
    .flip        (flip),
    .rom_addr    (rom_addr),
    .rom_cs      (rom_cs),
    .rom_data    (rom_data),
    .rom_ok      (rom_ok),
    .char_pxl    (char_pxl),
    .char_opaque (char_opaque)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One CPU bus write; scr selects the scroll registers instead of map RAM.
  task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d, input logic scr);
    cpu_AB   = a;
    cpu_dout = d;
    char_cs  = ~scr;
    scr_cs   = scr;
    cpu_wrn  = 1'b0;
    cen_E    = 1'b1;
    @(posedge clk); #1;
    cpu_wrn  = 1'b1;
    cen_E    = 1'b0;
    char_cs  = 1'b0;
    scr_cs   = 1'b0;
  endtask

  task automatic cpu_rd(input logic [10:0] a, output logic [7:0] d);
    cpu_AB  = a;
    char_cs = 1'b1;
    #1;
    d       = char_dout;
    char_cs = 1'b0;
  endtask

  // One pixel: an idle clock, then a clock with pxl_cen high at position h.
  task automatic pix(input logic [7:0] h);
    @(posedge clk); #1;
    HPOS    = h;
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    rst_n    = 1'b0;
    pxl_cen  = 1'b0;
    cen_E    = 1'b0;
    cpu_AB   = '0;
    cpu_wrn  = 1'b1;
    cpu_dout = '0;
    char_cs  = 1'b0;
    scr_cs   = 1'b0;
    HPOS     = '0;
    VPOS     = '0;
    flip     = 1'b0;
    rom_data = '0;
    rom_ok   = 1'b1;

    #12;
    check("rst_pxl",    char_pxl,    0);
    check("rst_opaque", char_opaque, 0);
    check("rst_romcs",  rom_cs,      0);
    check("rst_romaddr", rom_addr,   0);
    rst_n = 1'b1;

    // Entry 0: code 0x234, palette 5, no tile flip.
    // Entry 1: code 0x056, palette 2, tile flip.
    cpu_wr(11'd0, 8'h34, 1'b0);
    cpu_wr(11'd1, 8'hA2, 1'b0);
    cpu_wr(11'd2, 8'h56, 1'b0);
    cpu_wr(11'd3, 8'h48, 1'b0);
    cpu_rd(11'd0, rd); check("rd_lo0", rd, 8'h34);
    cpu_rd(11'd1, rd); check("rd_hi0", rd, 8'hA2);

    // Scroll 0, VPOS 0: entry 0 for hx 0..7, entry 1 for hx 8..15.
    pix(8'd0);
    check("a_addr_h0", rom_addr, 15'h4680);
    check("a_romcs",   rom_cs,   1);
    pix(8'd1);
    rom_data = 8'hF0;               // sorted 0xCC
    pix(8'd2);
    check("a_addr_h2", rom_addr, 15'h4688);
    pix(8'd3);
    check("p3_pxl", char_pxl, 7'h5C);
    check("p3_opq", char_opaque, 1);
    rom_data = 8'hA5;               // sorted 0xC3
    pix(8'd4);
    check("p4_pxl", char_pxl, 7'h5C);
    pix(8'd5);
    check("p5_pxl", char_pxl, 7'h53);
    rom_ok = 1'b0;                  // miss at stage B
    pix(8'd6);
    check("p6_pxl", char_pxl, 7'h5C);
    rom_ok = 1'b1;
    rom_data = 8'h00;
    pix(8'd7);
    check("miss_pxl0", char_pxl, 7'h50);
    check("miss_opq0", char_opaque, 0);
    pix(8'd8);
    check("miss_pxl1", char_pxl, 7'h50);
    check("miss_opq1", char_opaque, 0);
    // Entry 1 fetched at hx 8 with flipped column pair 2'b11.
    check("tflip_addr", rom_addr, 15'h0AD8);
    pix(8'd9);
    rom_data = 8'hA5;
    pix(8'd10);
    pix(8'd11);
    check("tflip_pxl0", char_pxl, 7'h2C);   // high nibble first
    pix(8'd12);
    check("tflip_pxl1", char_pxl, 7'h23);

    // Scroll X = 0xF8.
    cpu_wr(11'd0, 8'hF8, 1'b1);
    pix(8'h10);                     // hx 0x08 -> column 1
    check("scrx_col1", rom_addr, 15'h0AD8);
    pix(8'h0C);                     // hx 0x04 -> column 0
    check("scrx_wrap", rom_addr, 15'h4690);
    cpu_wr(11'd1, 8'h03, 1'b1);     // scroll Y = 3
    pix(8'h0C);
    check("scry_row", rom_addr, 15'h4693);

    // Global flip with a flipped tile: hx = ~HPOS, vy = ~0xFF = 0.
    cpu_wr(11'd0, 8'h00, 1'b1);
    cpu_wr(11'd1, 8'h00, 1'b1);
    flip = 1'b1;
    VPOS = 8'hFF;
    pix(8'hF5);                     // hx 0x0A, column pair 01 ^ 11
    check("gflip_addr", rom_addr, 15'h0AD0);
    pix(8'hF4);
    rom_data = 8'hA5;
    pix(8'hF3);                     // hx 0x0C, stage B loads 0xC3
    pix(8'hF2);
    check("gflip_pxl0", char_pxl, 7'h23);   // low nibble first
    pix(8'hF1);
    check("gflip_pxl1", char_pxl, 7'h2C);

    // Asynchronous reset mid-line, away from any clock edge.
    cpu_wr(11'd0, 8'h40, 1'b1);
    cpu_wr(11'd1, 8'h08, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_pxl",     char_pxl,    0);
    check("arst_opaque",  char_opaque, 0);
    check("arst_romcs",   rom_cs,      0);
    check("arst_romaddr", rom_addr,    0);
    #2;
    rst_n = 1'b1;
    flip  = 1'b0;
    VPOS  = 8'h00;
    // Scroll back to 0: hx 0x0C -> entry 1, column pair 10 ^ 11.
    pix(8'h0C);
    check("arst_scroll", rom_addr, 15'h0AC8);
    check("arst_romcs1", rom_cs,   1);
    cpu_rd(11'd0, rd); check("ram_kept", rd, 8'h34);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
